// File: rtl/bist_pkg.sv
// Shared types and width helpers for the scan BIST controller slice.
package bist_pkg;

    // Default MISR signature width.
    localparam int SIG_W_DEFAULT = 16;

    // Controller sequencing states.
    typedef enum logic [2:0] {
        IDLE,
        INIT,
        SHIFT,
        CAPTURE,
        FLUSH,
        COMPARE,
        DONE
    } bist_state_t;

    // Shift counter only has to reach CHAIN_LEN-1; never narrower than one bit.
    function automatic int shift_cnt_w(input int chain_len);
        return (chain_len > 1) ? $clog2(chain_len) : 1;
    endfunction

    // Pattern counter must be able to hold NUM_PATTERNS itself.
    function automatic int pat_cnt_w(input int num_patterns);
        return (num_patterns > 0) ? $clog2(num_patterns + 1) : 1;
    endfunction

endpackage

// File: rtl/bist_controller_if.sv
// Handshake and status bundle between the BIST controller and the test
// access logic. SIG_OUT exists only when BIST_SIG_OUT_EN is defined.
interface bist_controller_if
    import bist_pkg::*;
#(
    parameter int SIG_W  = SIG_W_DEFAULT,
    parameter int PCNT_W = pat_cnt_w(256)
);

    logic              START;
    logic              ABORT;
    logic [SIG_W-1:0]  SIG_IN;
    logic              SE;
    logic              BIST_RST;
    logic              BUSY;
    logic              DONE;
    logic              PASS;
    logic [PCNT_W-1:0] PATTERN_CNT;
`ifdef BIST_SIG_OUT_EN
    logic [SIG_W-1:0]  SIG_OUT;

    modport master (
        output START, ABORT, SIG_IN,
        input  SE, BIST_RST, BUSY, DONE, PASS, PATTERN_CNT, SIG_OUT
    );

    modport slave (
        input  START, ABORT, SIG_IN,
        output SE, BIST_RST, BUSY, DONE, PASS, PATTERN_CNT, SIG_OUT
    );
`else
    modport master (
        output START, ABORT, SIG_IN,
        input  SE, BIST_RST, BUSY, DONE, PASS, PATTERN_CNT
    );

    modport slave (
        input  START, ABORT, SIG_IN,
        output SE, BIST_RST, BUSY, DONE, PASS, PATTERN_CNT
    );
`endif

endinterface

// File: rtl/bist_phase_counter.sv
// Loadable up-counter with a terminal-count flag, used for both the shift
// count within a pattern and the number of patterns captured.
module bist_phase_counter #(
    parameter int               WIDTH    = 4,
    parameter logic [WIDTH-1:0] TERMINAL = '1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             inc,
    output logic [WIDTH-1:0] count,
    output logic             tc
);

    // Load has priority over increment so a phase can restart on the same edge it ends.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (inc) begin
            count <= count + 1'b1;
        end
    end

    assign tc = (count == TERMINAL);

endmodule

// File: rtl/bist_controller.sv
// Scan BIST sequencer: resets LFSR/MISR, alternates shift and capture for
// NUM_PATTERNS patterns, flushes the last response into the MISR and compares
// the signature with GOLDEN_SIG. Defining BIST_SIG_OUT_EN adds a SIG_OUT
// register holding the compared signature for the tester to read.
module bist_controller
    import bist_pkg::*;
#(
    parameter int               CHAIN_LEN    = 8,
    parameter int               NUM_PATTERNS = 256,
    parameter int               SIG_W        = SIG_W_DEFAULT,
    parameter logic [SIG_W-1:0] GOLDEN_SIG   = '0
) (
    input  logic              CLK,
    input  logic              RST,
    bist_controller_if.slave  bus
);

    localparam int SCNT_W = shift_cnt_w(CHAIN_LEN);
    localparam int PCNT_W = pat_cnt_w(NUM_PATTERNS);
    localparam logic [SCNT_W-1:0] SHIFT_LAST = SCNT_W'(CHAIN_LEN - 1);
    localparam logic [PCNT_W-1:0] PAT_LAST   = PCNT_W'(NUM_PATTERNS - 1);

    bist_state_t        state;
    bist_state_t        next_state;

    logic               abort_hit;
    logic               shift_active;
    logic               shift_load;
    logic               shift_tc;
    logic [SCNT_W-1:0]  shift_cnt_unused;
    logic               pat_load;
    logic               pat_inc;
    logic               pat_tc;
    logic [PCNT_W-1:0]  pat_cnt;
    logic               pass_q;

    // ABORT only matters once a run has left IDLE.
    assign abort_hit    = bus.ABORT && (state != IDLE);
    assign shift_active = (state == SHIFT) || (state == FLUSH);

    // The shift counter runs in SHIFT and FLUSH and is parked at zero everywhere
    // else, so every shift phase starts from zero; only its terminal flag is used.
    assign shift_load = abort_hit || !shift_active || shift_tc;

    bist_phase_counter #(
        .WIDTH    (SCNT_W),
        .TERMINAL (SHIFT_LAST)
    ) u_shift_cnt (
        .clk      (CLK),
        .rst      (RST),
        .load     (shift_load),
        .load_val ('0),
        .inc      (shift_active),
        .count    (shift_cnt_unused),
        .tc       (shift_tc)
    );

    // The pattern counter clears at the start of a run and counts captures.
    assign pat_load = abort_hit || (state == INIT);
    assign pat_inc  = (state == CAPTURE);

    bist_phase_counter #(
        .WIDTH    (PCNT_W),
        .TERMINAL (PAT_LAST)
    ) u_pat_cnt (
        .clk      (CLK),
        .rst      (RST),
        .load     (pat_load),
        .load_val ('0),
        .inc      (pat_inc),
        .count    (pat_cnt),
        .tc       (pat_tc)
    );

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; ABORT overrides every transition out of a non-IDLE state.
    always_comb begin
        next_state = state;
        if (abort_hit) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.START && !bus.ABORT) begin
                        next_state = INIT;
                    end
                end
                INIT: begin
                    next_state = SHIFT;
                end
                SHIFT: begin
                    if (shift_tc) begin
                        next_state = CAPTURE;
                    end
                end
                CAPTURE: begin
                    // pat_tc means this capture brings the count up to NUM_PATTERNS.
                    next_state = pat_tc ? FLUSH : SHIFT;
                end
                FLUSH: begin
                    if (shift_tc) begin
                        next_state = COMPARE;
                    end
                end
                COMPARE: begin
                    next_state = DONE;
                end
                DONE: begin
                    if (bus.START) begin
                        next_state = INIT;
                    end
                end
                default: begin
                    next_state = IDLE;
                end
            endcase
        end
    end

    // Moore outputs decoded from the state; BIST_RST also follows RST directly.
    always_comb begin
        bus.SE       = 1'b0;
        bus.BUSY     = 1'b0;
        bus.DONE     = 1'b0;
        bus.BIST_RST = RST;
        case (state)
            INIT: begin
                bus.BIST_RST = 1'b1;
                bus.BUSY     = 1'b1;
            end
            SHIFT, FLUSH: begin
                bus.SE   = 1'b1;
                bus.BUSY = 1'b1;
            end
            CAPTURE, COMPARE: begin
                bus.BUSY = 1'b1;
            end
            DONE: begin
                bus.DONE = 1'b1;
            end
            default: begin
                bus.SE = 1'b0;
            end
        endcase
    end

    // PASS is latched in COMPARE and dropped when a new run starts or on abort.
    always_ff @(posedge CLK) begin
        if (RST) begin
            pass_q <= 1'b0;
        end else if (abort_hit) begin
            pass_q <= 1'b0;
        end else if (state == COMPARE) begin
            pass_q <= (bus.SIG_IN == GOLDEN_SIG);
        end else if ((state == DONE) && bus.START) begin
            pass_q <= 1'b0;
        end
    end

    assign bus.PASS        = pass_q;
    assign bus.PATTERN_CNT = pat_cnt;

`ifdef BIST_SIG_OUT_EN
    logic [SIG_W-1:0] sig_q;

    // Capture the compared signature so a failing value can be read back.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sig_q <= '0;
        end else if (abort_hit || (state == INIT)) begin
            sig_q <= '0;
        end else if (state == COMPARE) begin
            sig_q <= bus.SIG_IN;
        end
    end

    assign bus.SIG_OUT = sig_q;
`endif

endmodule

// File: tb/tb_bist_controller.sv
// Directed bench for bist_controller with CHAIN_LEN=4, NUM_PATTERNS=2,
// GOLDEN_SIG=16'hBEEF. SIG_OUT is checked when BIST_SIG_OUT_EN is defined.
module tb_bist_controller;

    localparam int          CHAIN_LEN    = 4;
    localparam int          NUM_PATTERNS = 2;
    localparam int          SIG_W        = 16;
    localparam logic [15:0] GOLDEN       = 16'hBEEF;
    localparam int          PCNT_W       = bist_pkg::pat_cnt_w(NUM_PATTERNS);
    localparam logic [13:0] SE_EXP       = 14'b11110111101111;

    logic CLK = 1'b0;
    logic RST;

    bist_controller_if #(.SIG_W(SIG_W), .PCNT_W(PCNT_W)) bus ();

    bist_controller #(
        .CHAIN_LEN    (CHAIN_LEN),
        .NUM_PATTERNS (NUM_PATTERNS),
        .SIG_W        (SIG_W),
        .GOLDEN_SIG   (GOLDEN)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;

    logic [13:0]       se_seq;
    int                done_edge;
    logic              r_rst0, r_rst1, r_pass0, r_done0, r_busy0;
    logic              r_pass_done, r_busy_done;
    logic [PCNT_W-1:0] r_pcnt;

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Start a run from IDLE or DONE and record what happens up to DONE (bounded).
    task automatic run_capture(input bit hold_start, input bit toggle_start);
        bus.START = 1'b1;
        step();
        r_rst0  = bus.BIST_RST;
        r_pass0 = bus.PASS;
        r_done0 = bus.DONE;
        r_busy0 = bus.BUSY;
        if (!hold_start) bus.START = 1'b0;
        se_seq      = '0;
        done_edge   = 0;
        r_rst1      = 1'bx;
        r_pass_done = 1'bx;
        r_busy_done = 1'bx;
        r_pcnt      = 'x;
        for (int k = 1; k <= 40; k++) begin
            if (toggle_start) bus.START = k[0];
            step();
            if (k == 1) r_rst1 = bus.BIST_RST;
            if (k <= 14) se_seq[14-k] = bus.SE;
            if (bus.DONE === 1'b1) begin
                done_edge   = k;
                r_pass_done = bus.PASS;
                r_pcnt      = bus.PATTERN_CNT;
                r_busy_done = bus.BUSY;
                break;
            end
        end
    endtask

    task automatic test_reset();
        RST = 1'b1; bus.START = 1'b1; bus.ABORT = 1'b0; bus.SIG_IN = '0;
        step();
        step();
        checks++; if (bus.SE !== 1'b0) begin errors++; $display("[TB] FAIL reset_se: got %b expected 0", bus.SE); end
        checks++; if (bus.BIST_RST !== 1'b1) begin errors++; $display("[TB] FAIL reset_bist_rst: got %b expected 1", bus.BIST_RST); end
        checks++; if (bus.BUSY !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", bus.BUSY); end
        checks++; if (bus.DONE !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", bus.DONE); end
        checks++; if (bus.PASS !== 1'b0) begin errors++; $display("[TB] FAIL reset_pass: got %b expected 0", bus.PASS); end
        checks++; if (bus.PATTERN_CNT !== 2'd0) begin errors++; $display("[TB] FAIL reset_pcnt: got %0d expected 0", bus.PATTERN_CNT); end
`ifdef BIST_SIG_OUT_EN
        checks++; if (bus.SIG_OUT !== 16'h0000) begin errors++; $display("[TB] FAIL reset_sig_out: got %h expected 0000", bus.SIG_OUT); end
`endif
        RST = 1'b0; bus.START = 1'b0;
        step();
        checks++; if (bus.BIST_RST !== 1'b0) begin errors++; $display("[TB] FAIL idle_bist_rst: got %b expected 0", bus.BIST_RST); end
        checks++; if (bus.BUSY !== 1'b0) begin errors++; $display("[TB] FAIL idle_busy: got %b expected 0", bus.BUSY); end
        checks++; if (bus.SE !== 1'b0) begin errors++; $display("[TB] FAIL idle_se: got %b expected 0", bus.SE); end
    endtask

    task automatic test_nominal();
        bus.SIG_IN = 16'hBEEF;
        run_capture(1'b0, 1'b0);
        checks++; if (r_rst0 !== 1'b1) begin errors++; $display("[TB] FAIL nom_bist_rst_init: got %b expected 1", r_rst0); end
        checks++; if (r_busy0 !== 1'b1) begin errors++; $display("[TB] FAIL nom_busy_init: got %b expected 1", r_busy0); end
        checks++; if (r_rst1 !== 1'b0) begin errors++; $display("[TB] FAIL nom_bist_rst_one_cycle: got %b expected 0", r_rst1); end
        checks++; if (se_seq !== SE_EXP) begin errors++; $display("[TB] FAIL nom_se_seq: got %b expected %b", se_seq, SE_EXP); end
        checks++; if (done_edge !== 16) begin errors++; $display("[TB] FAIL nom_done_edge: got %0d expected 16", done_edge); end
        checks++; if (r_pass_done !== 1'b1) begin errors++; $display("[TB] FAIL nom_pass: got %b expected 1", r_pass_done); end
        checks++; if (r_pcnt !== 2'd2) begin errors++; $display("[TB] FAIL nom_pcnt: got %0d expected 2", r_pcnt); end
        checks++; if (r_busy_done !== 1'b0) begin errors++; $display("[TB] FAIL nom_busy_done: got %b expected 0", r_busy_done); end
        step();
        checks++; if (bus.DONE !== 1'b1) begin errors++; $display("[TB] FAIL nom_done_hold: got %b expected 1", bus.DONE); end
        checks++; if (bus.PASS !== 1'b1) begin errors++; $display("[TB] FAIL nom_pass_hold: got %b expected 1", bus.PASS); end
    endtask

    task automatic test_fail();
        bus.SIG_IN = 16'hBEEE;
        run_capture(1'b0, 1'b0);
        checks++; if (r_pass0 !== 1'b0) begin errors++; $display("[TB] FAIL fail_pass_cleared: got %b expected 0", r_pass0); end
        checks++; if (done_edge !== 16) begin errors++; $display("[TB] FAIL fail_done_edge: got %0d expected 16", done_edge); end
        checks++; if (r_pass_done !== 1'b0) begin errors++; $display("[TB] FAIL fail_pass: got %b expected 0", r_pass_done); end
`ifdef BIST_SIG_OUT_EN
        checks++; if (bus.SIG_OUT !== 16'hBEEE) begin errors++; $display("[TB] FAIL fail_sig_out: got %h expected beee", bus.SIG_OUT); end
`endif
    endtask

    task automatic test_abort();
        bus.SIG_IN = 16'hBEEF;
        bus.START = 1'b1;
        step();
        bus.START = 1'b0;
        repeat (6) step();
        checks++; if (bus.SE !== 1'b1) begin errors++; $display("[TB] FAIL abort_pre_se: got %b expected 1", bus.SE); end
        checks++; if (bus.PATTERN_CNT !== 2'd1) begin errors++; $display("[TB] FAIL abort_pre_pcnt: got %0d expected 1", bus.PATTERN_CNT); end
        bus.ABORT = 1'b1;
        step();
        checks++; if (bus.SE !== 1'b0) begin errors++; $display("[TB] FAIL abort_se: got %b expected 0", bus.SE); end
        checks++; if (bus.BUSY !== 1'b0) begin errors++; $display("[TB] FAIL abort_busy: got %b expected 0", bus.BUSY); end
        checks++; if (bus.DONE !== 1'b0) begin errors++; $display("[TB] FAIL abort_done: got %b expected 0", bus.DONE); end
        checks++; if (bus.PATTERN_CNT !== 2'd0) begin errors++; $display("[TB] FAIL abort_pcnt: got %0d expected 0", bus.PATTERN_CNT); end
        bus.START = 1'b1;
        step();
        checks++; if (bus.BUSY !== 1'b0) begin errors++; $display("[TB] FAIL abort_start_idle_busy: got %b expected 0", bus.BUSY); end
        checks++; if (bus.BIST_RST !== 1'b0) begin errors++; $display("[TB] FAIL abort_start_idle_bist_rst: got %b expected 0", bus.BIST_RST); end
        bus.START = 1'b0; bus.ABORT = 1'b0;
        step();
    endtask

    task automatic test_start_ignore();
        bus.SIG_IN = 16'hBEEF;
        run_capture(1'b0, 1'b1);
        checks++; if (se_seq !== SE_EXP) begin errors++; $display("[TB] FAIL ignore_se_seq: got %b expected %b", se_seq, SE_EXP); end
        checks++; if (done_edge !== 16) begin errors++; $display("[TB] FAIL ignore_done_edge: got %0d expected 16", done_edge); end
        checks++; if (r_pass_done !== 1'b1) begin errors++; $display("[TB] FAIL ignore_pass: got %b expected 1", r_pass_done); end
        bus.START = 1'b0;
    endtask

    task automatic test_back_to_back();
        bus.SIG_IN = 16'hBEEF;
        run_capture(1'b1, 1'b0);
        checks++; if (r_pass0 !== 1'b0) begin errors++; $display("[TB] FAIL b2b_first_pass_cleared: got %b expected 0", r_pass0); end
        checks++; if (done_edge !== 16) begin errors++; $display("[TB] FAIL b2b_first_done_edge: got %0d expected 16", done_edge); end
        checks++; if (r_pass_done !== 1'b1) begin errors++; $display("[TB] FAIL b2b_first_pass: got %b expected 1", r_pass_done); end
        run_capture(1'b1, 1'b0);
        checks++; if (r_done0 !== 1'b0) begin errors++; $display("[TB] FAIL b2b_done_one_cycle: got %b expected 0", r_done0); end
        checks++; if (r_rst0 !== 1'b1) begin errors++; $display("[TB] FAIL b2b_bist_rst: got %b expected 1", r_rst0); end
        checks++; if (r_pass0 !== 1'b0) begin errors++; $display("[TB] FAIL b2b_pass_cleared: got %b expected 0", r_pass0); end
        checks++; if (r_busy0 !== 1'b1) begin errors++; $display("[TB] FAIL b2b_busy_init: got %b expected 1", r_busy0); end
        checks++; if (se_seq !== SE_EXP) begin errors++; $display("[TB] FAIL b2b_se_seq: got %b expected %b", se_seq, SE_EXP); end
        checks++; if (done_edge !== 16) begin errors++; $display("[TB] FAIL b2b_second_done_edge: got %0d expected 16", done_edge); end
        checks++; if (r_pass_done !== 1'b1) begin errors++; $display("[TB] FAIL b2b_second_pass: got %b expected 1", r_pass_done); end
        bus.START = 1'b0;
    endtask

    task automatic test_mid_reset();
        bus.START = 1'b1;
        step();
        bus.START = 1'b0;
        repeat (12) step();
        checks++; if (bus.SE !== 1'b1) begin errors++; $display("[TB] FAIL midrst_flush_se: got %b expected 1", bus.SE); end
        checks++; if (bus.PATTERN_CNT !== 2'd2) begin errors++; $display("[TB] FAIL midrst_flush_pcnt: got %0d expected 2", bus.PATTERN_CNT); end
        RST = 1'b1; bus.START = 1'b1;
        #1;
        checks++; if (bus.BIST_RST !== 1'b1) begin errors++; $display("[TB] FAIL midrst_bist_rst_comb: got %b expected 1", bus.BIST_RST); end
        step();
        checks++; if (bus.SE !== 1'b0) begin errors++; $display("[TB] FAIL midrst_se: got %b expected 0", bus.SE); end
        checks++; if (bus.BUSY !== 1'b0) begin errors++; $display("[TB] FAIL midrst_busy: got %b expected 0", bus.BUSY); end
        checks++; if (bus.DONE !== 1'b0) begin errors++; $display("[TB] FAIL midrst_done: got %b expected 0", bus.DONE); end
        checks++; if (bus.PASS !== 1'b0) begin errors++; $display("[TB] FAIL midrst_pass: got %b expected 0", bus.PASS); end
        checks++; if (bus.PATTERN_CNT !== 2'd0) begin errors++; $display("[TB] FAIL midrst_pcnt: got %0d expected 0", bus.PATTERN_CNT); end
        checks++; if (bus.BIST_RST !== 1'b1) begin errors++; $display("[TB] FAIL midrst_bist_rst: got %b expected 1", bus.BIST_RST); end
        RST = 1'b0; bus.START = 1'b0;
        step();
        checks++; if (bus.BIST_RST !== 1'b0) begin errors++; $display("[TB] FAIL midrst_release_bist_rst: got %b expected 0", bus.BIST_RST); end
        checks++; if (bus.BUSY !== 1'b0) begin errors++; $display("[TB] FAIL midrst_release_busy: got %b expected 0", bus.BUSY); end
    endtask

    initial begin
        $display("[TB] bist_controller directed tests starting");
        test_reset();
        test_nominal();
        test_fail();
        test_abort();
        test_start_ignore();
        test_back_to_back();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
